// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and helpers for the serial nibble adder.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned NIBBLE_W = 4;

   // Counter width that never collapses to zero bits.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_nibble_adder_rca4.sv
// 4-bit ripple-carry adder cell used as the nibble datapath.
module serial_nibble_adder_rca4
   import serial_add_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a_i,
   input  logic [NIBBLE_W-1:0] b_i,
   input  logic                cin_i,
   output logic [NIBBLE_W-1:0] sum_o,
   output logic                cout_o
);

   logic carry;

   always_comb begin
      sum_o = '0;
      carry = cin_i;
      for (int i = 0; i < NIBBLE_W; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      cout_o = carry;
   end

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle W-bit adder: one nibble per cycle through a 4-bit cell, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_nibble_adder
   import serial_add_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0]  a,
   input  logic [NIBBLE_W*NIBBLES-1:0]  b,
   input  logic                         cin,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0]  sum,
   output logic                         cout,
   output logic                         busy
`ifdef SERIAL_ADD_OVF_EN
   ,output logic                        ovf
`endif
);

   localparam int unsigned W    = NIBBLE_W * NIBBLES;
   localparam int unsigned IdxW = clog2_min1(NIBBLES);

   state_e              state_q, state_d;
   logic [W-1:0]        a_q, a_d;
   logic [W-1:0]        b_q, b_d;
   logic [W-1:0]        sum_q, sum_d;
   logic                carry_q, carry_d;
   logic                cout_q, cout_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [NIBBLE_W-1:0] cell_a, cell_b, cell_sum;
   logic                cell_cout;
   logic                last;
`ifdef SERIAL_ADD_OVF_EN
   logic                ovf_q, ovf_d;
`endif

   assign cell_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
   assign cell_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
   assign last   = (idx_q == IdxW'(NIBBLES - 1));

   serial_nibble_adder_rca4 u_cell (
      .a_i    (cell_a),
      .b_i    (cell_b),
      .cin_i  (carry_q),
      .sum_o  (cell_sum),
      .cout_o (cell_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = cell_sum;
            carry_d = cell_cout;
            idx_d   = idx_q + 1'b1;
            if (last) begin
               cout_d  = cell_cout;
               idx_d   = '0;
               state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (cell_sum[NIBBLE_W-1] != a_q[W-1]);
`endif
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed self-checking bench for serial_nibble_adder (NIBBLES=4 and NIBBLES=1 instances).
module tb_serial_nibble_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [15:0] a, b, sum;
   logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
   logic [3:0]  a1, b1, sum1;
`ifdef SERIAL_ADD_OVF_EN
   logic        ovf, ovf1;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   serial_nibble_adder #(.NIBBLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
      ,.ovf      (ovf)
`endif
   );

   serial_nibble_adder #(.NIBBLES(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .cin       (cin1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum       (sum1),
      .cout      (cout1),
      .busy      (busy1)
`ifdef SERIAL_ADD_OVF_EN
      ,.ovf      (ovf1)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand pair; return cycles from accept edge until out_valid.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         output int lat);
      a = ta; b = tb_; cin = tc; in_valid = 1'b1;
      check_eq("in_ready_before_accept", in_ready, 1);
      tick();
      in_valid = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0;
      check_eq("busy_after_accept", busy, 1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("out_valid_after_release", out_valid, 0);
      check_eq("in_ready_after_release", in_ready, 1);
   endtask

   int lat;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_sum", sum, 0);
      check_eq("rst_cout", cout, 0);

      // Carry ripple across all nibbles
      run_op(16'hFFFF, 16'h0001, 1'b0, lat);
      check_eq("ripple_latency", lat, 4);
      check_eq("ripple_sum", sum, 16'h0000);
      check_eq("ripple_cout", cout, 1);
      release_out();

      run_op(16'h1234, 16'h4321, 1'b1, lat);
      check_eq("plain_latency", lat, 4);
      check_eq("plain_sum", sum, 16'h5556);
      check_eq("plain_cout", cout, 0);

      // Hold in DONE with a competing offer
      in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("hold_out_valid", out_valid, 1);
         check_eq("hold_sum", sum, 16'h5556);
         check_eq("hold_cout", cout, 0);
         check_eq("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      release_out();
      check_eq("idle_busy", busy, 0);

      // Reset mid-operation at idx=2
      a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_in_ready", in_ready, 1);
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_sum", sum, 0);
      check_eq("midrst_cout", cout, 0);
      run_op(16'h0F0F, 16'h00F1, 1'b0, lat);
      check_eq("postrst_latency", lat, 4);
      check_eq("postrst_sum", sum, 16'h1000);
      check_eq("postrst_cout", cout, 0);
      release_out();

`ifdef SERIAL_ADD_OVF_EN
      run_op(16'h7FFF, 16'h0001, 1'b0, lat);
      check_eq("ovf_pos_sum", sum, 16'h8000);
      check_eq("ovf_pos_flag", ovf, 1);
      release_out();
      run_op(16'hFFFF, 16'h0001, 1'b0, lat);
      check_eq("ovf_neg_flag", ovf, 0);
      check_eq("ovf_neg_cout", cout, 1);
      release_out();
`endif

      // Single-nibble instance: one RUN cycle
      a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1; in_valid1 = 1'b1;
      check_eq("n1_in_ready", in_ready1, 1);
      tick();
      in_valid1 = 1'b0;
      check_eq("n1_busy", busy1, 1);
      check_eq("n1_not_done_yet", out_valid1, 0);
      tick();
      check_eq("n1_out_valid", out_valid1, 1);
      check_eq("n1_sum", sum1, 4'hF);
      check_eq("n1_cout", cout1, 1);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check_eq("n1_in_ready_after", in_ready1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
